// File: rtl/vram_draw_if.sv
// Command, sprite-fetch and VRAM port bundle for the sprite/clear draw engine.
interface vram_draw_if #(
    parameter int MEM_AW = 12
);
    // command handshake
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [6:0]        cmd_x;
    logic [5:0]        cmd_y;
    logic [3:0]        cmd_n;
    logic [MEM_AW-1:0] cmd_addr;
    logic [1:0]        cmd_planes;
    // sprite memory
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data;
    // VRAM port
    logic [6:0]        vram_hpos;
    logic [5:0]        vram_vpos;
    logic [1:0]        vram_pixeli;
    logic [1:0]        vram_pixelo;
    logic              vram_we;
    // status
    logic              busy;
    logic              done;
    logic              collision;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, cmd_planes,
        input  mem_data, vram_pixelo,
        output cmd_ready, mem_rd, mem_addr,
        output vram_hpos, vram_vpos, vram_pixeli, vram_we,
        output busy, done, collision
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_addr, cmd_planes,
        output mem_data, vram_pixelo,
        input  cmd_ready, mem_rd, mem_addr,
        input  vram_hpos, vram_vpos, vram_pixeli, vram_we,
        input  busy, done, collision
    );
endinterface

// File: rtl/vram_draw_ctrl.sv
// Sprite draw / screen clear engine for a 128x64, 2-bit-per-pixel VRAM.
// DRAW XORs an 8-pixel-wide sprite (one byte per row) into VRAM with
// read-modify-write per pixel, clipping at the right/bottom edges and
// flagging collisions; CLEAR writes zero to every pixel.
module vram_draw_ctrl #(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    vram_draw_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, FWAIT, PRD, PWR, DONE} state_t;

    state_t            state;
    logic [6:0]        x_q;
    logic [5:0]        y_q;
    logic [3:0]        n_q;
    logic [MEM_AW-1:0] addr_q;
    logic [1:0]        planes_q;
    logic [3:0]        row;
    logic [2:0]        col;
    logic [7:0]        shreg;
    logic              hclip;
    logic              vclip;
    logic              rdy_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              coll_q;
    logic              mem_rd_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [6:0]        hpos;
    logic [5:0]        vpos;

    // Pixel position of the column entering PRD: column 0 from FWAIT,
    // column+1 from PWR. The extra top bit flags a clipped pixel.
    logic [7:0] h_sum;
    logic [6:0] v_sum;
    assign h_sum = {1'b0, x_q} + ((state == PWR) ? ({5'd0, col} + 8'd1) : 8'd0);
    assign v_sum = {1'b0, y_q} + {3'd0, row};

    // Gating with reset_n keeps a write from landing on the reset edge
    // and holds cmd_ready low while reset is asserted.
    assign bus.cmd_ready   = rdy_q & reset_n;
    assign bus.vram_we     = we_q & reset_n;
    assign bus.vram_pixeli = (state == PWR) ?
                             (bus.vram_pixelo ^ ({2{shreg[7]}} & planes_q)) : 2'b00;
    assign bus.vram_hpos   = hpos;
    assign bus.vram_vpos   = vpos;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.collision   = coll_q;

    // Main FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            we_q       <= 1'b0;
            hpos       <= '0;
            vpos       <= '0;
            row        <= '0;
            col        <= '0;
            hclip      <= 1'b0;
            vclip      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && rdy_q) begin
                        x_q      <= bus.cmd_x;
                        y_q      <= bus.cmd_y;
                        n_q      <= bus.cmd_n;
                        addr_q   <= bus.cmd_addr;
                        planes_q <= bus.cmd_planes;
                        coll_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        rdy_q    <= 1'b0;
                        if (!bus.cmd_op) begin
                            state <= CLEAR;
                            hpos  <= '0;
                            vpos  <= '0;
                            we_q  <= 1'b1;
                        end else begin
                            // An empty sprite spends one bus-quiet cycle in
                            // FETCH before finishing.
                            state      <= FETCH;
                            row        <= '0;
                            mem_rd_q   <= (bus.cmd_n != 4'd0);
                            mem_addr_q <= bus.cmd_addr;
                        end
                    end
                end
                CLEAR: begin
                    {vpos, hpos} <= {vpos, hpos} + 13'd1;
                    if ({vpos, hpos} == 13'h1FFF) begin
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                FETCH: begin
                    mem_rd_q <= 1'b0;
                    if (n_q == 4'd0) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= FWAIT;
                    end
                end
                FWAIT: begin
                    shreg <= bus.mem_data;
                    col   <= '0;
                    hpos  <= h_sum[6:0];
                    hclip <= h_sum[7];
                    vpos  <= v_sum[5:0];
                    vclip <= v_sum[6];
                    state <= PRD;
                end
                PRD: begin
                    we_q  <= shreg[7] & ~hclip & ~vclip;
                    state <= PWR;
                end
                PWR: begin
                    we_q  <= 1'b0;
                    if (we_q && ((bus.vram_pixelo & planes_q) != 2'b00))
                        coll_q <= 1'b1;
                    shreg <= {shreg[6:0], 1'b0};
                    if (col == 3'd7) begin
                        if (row == n_q - 4'd1) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            row        <= row + 4'd1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= addr_q + MEM_AW'(row) + MEM_AW'(1);
                            state      <= FETCH;
                        end
                    end else begin
                        col   <= col + 3'd1;
                        hpos  <= h_sum[6:0];
                        hclip <= h_sum[7];
                        state <= PRD;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_draw_ctrl.sv
// Directed bench for vram_draw_ctrl with behavioural VRAM and sprite ROM.
module tb_vram_draw_ctrl;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    vram_draw_if #(.MEM_AW(12)) bus();

    vram_draw_ctrl #(.MEM_AW(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] vram [8192];
    logic [7:0] rom  [4096];
    logic       fill_req;
    logic [1:0] fill_val;
    int         wr_cnt;
    int         nz_wr_cnt;
    int         rd_cnt;
    int         acc_cnt;

    initial begin
        wr_cnt = 0; nz_wr_cnt = 0; rd_cnt = 0; acc_cnt = 0;
    end

    // Behavioural VRAM (1-cycle read), sprite ROM and activity counters.
    always @(posedge clk) begin
        bus.vram_pixelo <= vram[{bus.vram_vpos, bus.vram_hpos}];
        if (fill_req) begin
            for (int i = 0; i < 8192; i++) vram[i] <= fill_val;
        end else if (bus.vram_we) begin
            vram[{bus.vram_vpos, bus.vram_hpos}] <= bus.vram_pixeli;
            wr_cnt <= wr_cnt + 1;
            if (bus.vram_pixeli != 2'b00) nz_wr_cnt <= nz_wr_cnt + 1;
        end
        if (bus.mem_rd) begin
            bus.mem_data <= rom[bus.mem_addr];
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [1:0] v);
        fill_val = v;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic send(input logic op, input int x, input int y, input int n,
                        input int addr, input logic [1:0] planes);
        bus.cmd_op     = op;
        bus.cmd_x      = 7'(x);
        bus.cmd_y      = 6'(y);
        bus.cmd_n      = 4'(n);
        bus.cmd_addr   = 12'(addr);
        bus.cmd_planes = planes;
        bus.cmd_valid  = 1'b1;
        @(negedge clk);
        bus.cmd_valid  = 1'b0;
    endtask

    // Starts at the negedge of cycle 'start' after accept; returns the cycle
    // index at which done was seen (limit if it never came).
    task automatic wait_done(input int start, input int limit, output int cyc);
        cyc = start;
        while (!bus.done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic int count_nz();
        int c = 0;
        for (int i = 0; i < 8192; i++) if (vram[i] != 2'b00) c++;
        return c;
    endfunction

    function automatic int vi(input int x, input int y);
        return y * 128 + x;
    endfunction

    int cyc;
    int w0, nz0, r0, a0;

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0;
        fill_req = 1'b0; fill_val = 2'b00;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.cmd_n = '0; bus.cmd_addr = '0; bus.cmd_planes = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h010] = 8'hA5;
        for (int i = 0; i < 4; i++) rom[12'h020 + i] = 8'hFF;
        rom[12'h030] = 8'h80;

        // ---- reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_done",      32'(bus.done), 0);
        chk("rst_collision", 32'(bus.collision), 0);
        chk("rst_mem_rd",    32'(bus.mem_rd), 0);
        chk("rst_vram_we",   32'(bus.vram_we), 0);
        chk("rst_pos",       32'({bus.vram_vpos, bus.vram_hpos, bus.vram_pixeli}), 0);
        chk("rst_mem_addr",  32'(bus.mem_addr), 0);
        reset_n = 1'b1;
        #1 chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        fill(2'b00);

        // ---- DRAW 0xA5 at (0,0), planes 01, empty VRAM
        w0 = wr_cnt; r0 = rd_cnt;
        send(1'b1, 0, 0, 1, 12'h010, 2'b01);
        chk("draw1_busy", 32'(bus.busy), 1);
        wait_done(1, 200, cyc);
        chk("draw1_done_cycle", 32'(cyc), 19);
        chk("draw1_collision", 32'(bus.collision), 0);
        @(negedge clk);
        chk("draw1_done_pulse", 32'({bus.done, bus.busy, bus.cmd_ready}), 32'b001);
        chk("draw1_pixels", 32'({vram[0], vram[1], vram[2], vram[3], vram[4], vram[5], vram[6], vram[7]}),
            32'b01_00_01_00_00_01_00_01);
        chk("draw1_writes", 32'(wr_cnt - w0), 4);
        chk("draw1_reads",  32'(rd_cnt - r0), 1);

        // ---- same DRAW again: XOR back to zero, collision
        send(1'b1, 0, 0, 1, 12'h010, 2'b01);
        wait_done(1, 200, cyc);
        chk("draw2_done_cycle", 32'(cyc), 19);
        chk("draw2_collision", 32'(bus.collision), 1);
        @(negedge clk);
        chk("draw2_pixels", 32'(count_nz()), 0);

        // ---- CLEAR over all-11 VRAM
        fill(2'b11);
        w0 = wr_cnt; nz0 = nz_wr_cnt;
        send(1'b0, 5, 5, 3, 0, 2'b11);
        chk("clr_first", 32'({bus.vram_we, bus.vram_vpos, bus.vram_hpos, bus.vram_pixeli}), 32'h1_0000 >> 1);
        chk("clr_collision", 32'(bus.collision), 0);
        wait_done(1, 9000, cyc);
        chk("clr_done_cycle", 32'(cyc), 8193);
        chk("clr_writes",    32'(wr_cnt - w0), 8192);
        chk("clr_nz_writes", 32'(nz_wr_cnt - nz0), 0);
        @(negedge clk);
        chk("clr_all_zero",  32'(count_nz()), 0);
        chk("clr_idle",      32'({bus.busy, bus.vram_we}), 0);

        // ---- DRAW with n=0, cmd_valid held through busy
        w0 = wr_cnt; r0 = rd_cnt; a0 = acc_cnt;
        bus.cmd_op = 1'b1; bus.cmd_n = 4'd0; bus.cmd_planes = 2'b11;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        chk("n0_cyc1", 32'({bus.busy, bus.cmd_ready, bus.mem_rd, bus.done}), 32'b1000);
        @(negedge clk);
        chk("n0_done_cyc2", 32'({bus.done, bus.collision}), 32'b10);
        @(negedge clk);
        chk("n0_no_reaccept", 32'(acc_cnt - a0), 1);
        chk("n0_ready_idle",  32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b0;
        chk("n0_no_traffic",  32'((wr_cnt - w0) + (rd_cnt - r0)), 0);
        @(negedge clk);

        // ---- clipped DRAW at (124,62), 4 rows of 0xFF, planes 11
        w0 = wr_cnt; r0 = rd_cnt;
        send(1'b1, 124, 62, 4, 12'h020, 2'b11);
        wait_done(1, 300, cyc);
        chk("clip_done_cycle", 32'(cyc), 73);
        @(negedge clk);
        chk("clip_writes", 32'(wr_cnt - w0), 8);
        chk("clip_reads",  32'(rd_cnt - r0), 4);
        chk("clip_nz",     32'(count_nz()), 8);
        chk("clip_in",     32'({vram[vi(124, 62)], vram[vi(127, 62)], vram[vi(124, 63)], vram[vi(127, 63)]}), 32'hFF);
        chk("clip_wrap",   32'({vram[vi(0, 62)], vram[vi(3, 63)], vram[vi(124, 0)], vram[vi(127, 1)]}), 0);
        chk("clip_collision", 32'(bus.collision), 0);

        // ---- reset in the 100th CLEAR cycle, then DRAW in first IDLE cycle
        fill(2'b11);
        w0 = wr_cnt;
        send(1'b0, 0, 0, 0, 0, 2'b00);
        repeat (99) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_we_busy", 32'({bus.vram_we, bus.busy, bus.cmd_ready}), 0);
        chk("abort_writes",  32'(wr_cnt - w0), 99);
        chk("abort_vram",    32'({vram[98], vram[99], vram[vi(10, 5)]}), 32'b00_11_11);
        reset_n = 1'b1;
        a0 = acc_cnt;
        #1 chk("abort_ready", 32'(bus.cmd_ready), 1);
        send(1'b1, 10, 5, 1, 12'h030, 2'b10);
        chk("abort_accept", 32'({bus.busy, 4'(acc_cnt - a0)}), 32'h11);
        wait_done(1, 200, cyc);
        chk("abort_draw_cycle", 32'(cyc), 19);
        chk("abort_draw_coll",  32'(bus.collision), 1);
        @(negedge clk);
        chk("abort_draw_pixel", 32'(vram[vi(10, 5)]), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
